board_move_ctrl: RTL and testbench

- Sequential board engine for the 2048 game: holds the 4x4 tile board as 4-bit exponents (0 = empty, n = tile 2^n).
- On a move request it reads each of the 4 lines in the requested direction, slide-merges each line, and writes the result back.
- Spawns a new tile when the board changed, then updates score, win and game-over flags.
- Sits between the button/input decoder and the display/renderer.

---
 rtl/board_move_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_board_move_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_move_ctrl.sv
// 2048 board engine: slide-merges one line per cycle, spawns tiles, keeps score and win/lock flags.
// Define BOARD_UNDO_EN to add a single-level undo of the last board-changing move.
module board_move_ctrl #(
    parameter int unsigned WIN_EXP   = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
`ifdef BOARD_UNDO_EN
    input  logic        undo,
`endif
    output logic        move_ready,
    output logic        done,
    output logic        moved,
    output logic [63:0] board,
    output logic [31:0] score,
    output logic        won,
    output logic        game_over
);

    typedef enum logic [2:0] {
        StIdle, StLine0, StLine1, StLine2, StLine3, StSpawn, StFin
    } state_t;

    state_t      state;
    logic [1:0]  dir;
    logic [15:0] lfsr;
    logic [3:0]  idx;
    logic [3:0]  scan;
    logic [1:0]  spawn_cnt;

    logic [1:0]  line_k;
    logic [3:0]  cidx [4];
    logic [15:0] line_in;
    logic [15:0] line_out;
    logic [31:0] line_pts;
    logic        line_changed;
    logic [63:0] board_wr;
    logic [3:0]  spawn_cell;
    logic        lfsr_fb;
    logic        undo_go;

`ifdef BOARD_UNDO_EN
    logic [63:0] pend_board;
    logic [63:0] snap_board;
    logic [31:0] pend_score;
    logic [31:0] snap_score;
    logic        snap_valid;

    assign undo_go = undo & snap_valid;
`else
    assign undo_go = 1'b0;
`endif

    // Cell index of element j of line k when read in direction d (x0 is the slide target).
    function automatic logic [3:0] cell_idx(input logic [1:0] d, input logic [1:0] k,
                                            input logic [1:0] j);
        logic [3:0] r;
        case (d)
            2'd0:    r = {k, j};
            2'd1:    r = {k, ~j};
            2'd2:    r = {j, k};
            default: r = {~j, k};
        endcase
        return r;
    endfunction

    // Returns {points, merged line}; pend holds the last tile still eligible to merge.
    function automatic logic [47:0] merge_line(input logic [15:0] in);
        logic [15:0] out;
        logic [31:0] pts;
        logic [3:0]  pend;
        logic [3:0]  v;
        logic [3:0]  m;
        logic [1:0]  w;
        out  = '0;
        pts  = '0;
        pend = '0;
        m    = '0;
        w    = '0;
        for (int i = 0; i < 4; i++) begin
            v = in[4*i +: 4];
            if (v != 4'd0) begin
                if (v == pend) begin
                    m = (v == 4'd15) ? 4'd15 : v + 4'd1;
                    out[{w, 2'b00} +: 4] = m;
                    pts  = pts + (32'd1 << m);
                    w    = w + 2'd1;
                    pend = '0;
                end else begin
                    if (pend != 4'd0) begin
                        out[{w, 2'b00} +: 4] = pend;
                        w = w + 2'd1;
                    end
                    pend = v;
                end
            end
        end
        if (pend != 4'd0) out[{w, 2'b00} +: 4] = pend;
        return {pts, out};
    endfunction

    // Returns {won, game_over}.
    function automatic logic [1:0] board_flags(input logic [63:0] b);
        logic any_win;
        logic any_empty;
        logic any_pair;
        any_win   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (32'(b[4*i +: 4]) >= WIN_EXP) any_win = 1'b1;
            if (b[4*i +: 4] == 4'd0) any_empty = 1'b1;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (b[16*r + 4*c +: 4] == b[16*r + 4*c + 4 +: 4]) any_pair = 1'b1;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (b[16*r + 4*c +: 4] == b[16*r + 4*c + 16 +: 4]) any_pair = 1'b1;
            end
        end
        return {any_win, ~any_empty & ~any_pair};
    endfunction

    always_comb begin
        case (state)
            StLine1: line_k = 2'd1;
            StLine2: line_k = 2'd2;
            StLine3: line_k = 2'd3;
            default: line_k = 2'd0;
        endcase
        cidx    = '{default: '0};
        line_in = '0;
        for (int j = 0; j < 4; j++) begin
            cidx[j] = cell_idx(dir, line_k, 2'(j));
            line_in[4*j +: 4] = board[{cidx[j], 2'b00} +: 4];
        end
        {line_pts, line_out} = merge_line(line_in);
        line_changed = (line_out != line_in);
        board_wr = board;
        for (int j = 0; j < 4; j++) begin
            board_wr[{cidx[j], 2'b00} +: 4] = line_out[4*j +: 4];
        end
    end

    assign spawn_cell = board[{idx, 2'b00} +: 4];
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            dir        <= 2'd0;
            lfsr       <= LFSR_SEED;
            idx        <= 4'd0;
            scan       <= 4'd0;
            spawn_cnt  <= 2'd0;
            board      <= '0;
            score      <= '0;
            move_ready <= 1'b1;
            done       <= 1'b0;
            moved      <= 1'b0;
            won        <= 1'b0;
            game_over  <= 1'b0;
`ifdef BOARD_UNDO_EN
            pend_board <= '0;
            pend_score <= '0;
            snap_board <= '0;
            snap_score <= '0;
            snap_valid <= 1'b0;
`endif
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (new_game) begin
                        board      <= '0;
                        score      <= '0;
                        moved      <= 1'b0;
                        spawn_cnt  <= 2'd2;
                        idx        <= lfsr[3:0];
                        scan       <= 4'd0;
                        move_ready <= 1'b0;
                        state      <= StSpawn;
`ifdef BOARD_UNDO_EN
                        snap_valid <= 1'b0;
`endif
                    end else if (undo_go) begin
`ifdef BOARD_UNDO_EN
                        board      <= snap_board;
                        score      <= snap_score;
                        {won, game_over} <= board_flags(snap_board);
                        moved      <= 1'b0;
                        done       <= 1'b1;
                        snap_valid <= 1'b0;
`endif
                    end else if (move_valid && move_ready) begin
                        dir        <= move_dir;
                        moved      <= 1'b0;
                        move_ready <= 1'b0;
                        state      <= StLine0;
`ifdef BOARD_UNDO_EN
                        pend_board <= board;
                        pend_score <= score;
`endif
                    end
                end
                StLine0, StLine1, StLine2: begin
                    board <= board_wr;
                    score <= score + line_pts;
                    if (line_changed) moved <= 1'b1;
                    state <= (state == StLine0) ? StLine1 :
                             (state == StLine1) ? StLine2 : StLine3;
                end
                StLine3: begin
                    board <= board_wr;
                    score <= score + line_pts;
                    if (moved || line_changed) begin
                        moved     <= 1'b1;
                        spawn_cnt <= 2'd1;
                        idx       <= lfsr[3:0];
                        scan      <= 4'd0;
                        state     <= StSpawn;
                    end else begin
                        done  <= 1'b1;
                        state <= StFin;
                    end
                end
                StSpawn: begin
                    // A full 16-cell scan with no hole gives up on this tile.
                    if (spawn_cell == 4'd0 || scan == 4'd15) begin
                        if (spawn_cell == 4'd0) begin
                            board[{idx, 2'b00} +: 4] <= (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
                        end
                        idx       <= lfsr[3:0];
                        scan      <= 4'd0;
                        spawn_cnt <= spawn_cnt - 2'd1;
                        if (spawn_cnt == 2'd1) begin
                            done  <= 1'b1;
                            state <= StFin;
                        end
                    end else begin
                        idx  <= idx + 4'd1;
                        scan <= scan + 4'd1;
                    end
                end
                StFin: begin
                    {won, game_over} <= board_flags(board);
                    move_ready <= 1'b1;
                    state      <= StIdle;
`ifdef BOARD_UNDO_EN
                    if (moved) begin
                        snap_board <= pend_board;
                        snap_score <= pend_score;
                        snap_valid <= 1'b1;
                    end
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_board_move_ctrl.sv
// Scoreboard bench for board_move_ctrl: driver queues expected results, monitor checks on done.
module tb_board_move_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        done;
    logic        moved;
    logic [63:0] board;
    logic [31:0] score;
    logic        won;
    logic        game_over;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] board;
        logic [31:0] score;
        logic        moved;
        logic        chk_moved;
        int          nspawn;
        int          t_acc;
        logic        won;
        logic        go;
    } exp_t;

    exp_t sb[$];

    board_move_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .done       (done),
        .moved      (moved),
        .board      (board),
        .score      (score),
        .won        (won),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin : monitor
        exp_t       e;
        int         lat;
        int         p;
        int         k;
        int         nnew;
        int         kept;
        int         scan_ok;
        logic [3:0] a;
        logic [3:0] x;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.t_acc;
                    check("score", 64'(score), 64'(e.score));
                    if (e.chk_moved) check("moved", 64'(moved), 64'(e.moved));
                    kept = 1;
                    nnew = 0;
                    p    = -1;
                    for (int i = 0; i < 16; i++) begin
                        a = board[4*i +: 4];
                        x = e.board[4*i +: 4];
                        if (x != 4'd0) begin
                            if (a != x) kept = 0;
                        end else if (a == 4'd1 || a == 4'd2) begin
                            nnew++;
                            p = i;
                        end else if (a != 4'd0) begin
                            kept = 0;
                        end
                    end
                    chk_int("board_kept", kept, 1);
                    chk_int("new_tiles", nnew, e.nspawn);
                    if (e.nspawn == 0) begin
                        chk_int("latency_unmoved", lat, 5);
                    end else if (e.nspawn == 1) begin
                        // Latency 6+k means k occupied cells precede the spawn slot.
                        k = lat - 6;
                        scan_ok = (k >= 0 && k < 16 && p >= 0) ? 1 : 0;
                        if (scan_ok == 1) begin
                            for (int j = 1; j <= k; j++) begin
                                if (e.board[4*((p - j) & 15) +: 4] == 4'd0) scan_ok = 0;
                            end
                        end
                        chk_int("spawn_latency", scan_ok, 1);
                    end
                    @(negedge clk);
                    check("won", 64'(won), 64'(e.won));
                    check("game_over", 64'(game_over), 64'(e.go));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk_int("done_seen", int'(done === 1'b1), 1);
    endtask

    task automatic preload(input logic [63:0] b);
        @(negedge clk);
        force dut.board = b;
        @(negedge clk);
        release dut.board;
    endtask

    task automatic do_move(input logic [1:0] d, input logic [63:0] eb, input logic [31:0] es,
                           input logic em, input int ns, input logic ew, input logic eg,
                           input bit hold);
        exp_t e;
        @(negedge clk);
        move_dir    = d;
        move_valid  = 1'b1;
        e.board     = eb;
        e.score     = es;
        e.moved     = em;
        e.chk_moved = 1'b1;
        e.nspawn    = ns;
        e.t_acc     = cyc;
        e.won       = ew;
        e.go        = eg;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) move_valid = 1'b0;
        wait_done();
        move_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    localparam logic [63:0] Checker = 64'h1212_2121_1212_2121;

    initial begin : driver
        exp_t e;
        rst        = 1'b1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_dir   = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_board", board, 64'd0);
        check("rst_score", 64'(score), 64'd0);
        check("rst_ready", 64'(move_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_moved", 64'(moved), 64'd0);
        check("rst_won", 64'(won), 64'd0);
        check("rst_game_over", 64'(game_over), 64'd0);
        rst = 1'b0;

        preload(64'h2211);
        do_move(2'd0, 64'h0032, 32'd12, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        preload(64'h0222);
        do_move(2'd1, 64'h3200, 32'd20, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        preload(64'h0001);
        do_move(2'd0, 64'h0001, 32'd20, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_move(2'd2, 64'h0001, 32'd20, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        preload(Checker);
        do_move(2'd0, Checker, 32'd20, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        do_move(2'd3, Checker, 32'd20, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        preload(64'h00AA);
        do_move(2'd0, 64'h000B, 32'd2068, 1'b1, 1, 1'b1, 1'b0, 1'b0);

        // Reset while the engine is on the third line.
        preload(64'h0011);
        @(negedge clk);
        move_dir   = 2'd0;
        move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_before_rst", 64'(move_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_board", board, 64'd0);
        check("midrst_score", 64'(score), 64'd0);
        check("midrst_ready", 64'(move_ready), 64'd1);
        check("midrst_won", 64'(won), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        repeat (8) @(negedge clk);

        preload(64'h0011);
        do_move(2'd0, 64'h0002, 32'd4, 1'b1, 1, 1'b0, 1'b0, 1'b1);

        // new_game beats a simultaneous move request.
        @(negedge clk);
        new_game    = 1'b1;
        move_valid  = 1'b1;
        move_dir    = 2'd0;
        e.board     = 64'd0;
        e.score     = 32'd0;
        e.moved     = 1'b0;
        e.chk_moved = 1'b0;
        e.nspawn    = 2;
        e.t_acc     = cyc;
        e.won       = 1'b0;
        e.go        = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        new_game   = 1'b0;
        move_valid = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);

        chk_int("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
